// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: action codes, FSM states,
// the Booth group encoder and the iteration-count helper.
package booth_pkg;

  localparam logic [2:0] ACT_ZERO = 3'd0;
  localparam logic [2:0] ACT_PM   = 3'd1;
  localparam logic [2:0] ACT_P2M  = 3'd2;
  localparam logic [2:0] ACT_NM   = 3'd3;
  localparam logic [2:0] ACT_N2M  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int iter_count(input int width);
    return width / 2;
  endfunction

  // Group bits are {b[2i+1], b[2i], b[2i-1]}
  function automatic logic [2:0] booth_encode(input logic [2:0] grp);
    logic [2:0] act;
    case (grp)
      3'b001, 3'b010: act = ACT_PM;
      3'b011:         act = ACT_P2M;
      3'b100:         act = ACT_N2M;
      3'b101, 3'b110: act = ACT_NM;
      default:        act = ACT_ZERO;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Maps a Booth action code and multiplicand to a WIDTH+2 bit partial product.
// The extra two bits let -2M be represented even for the most negative M.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       act,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] m_ext;

  assign m_ext = {{2{m[WIDTH-1]}}, m};

  always_comb begin
    pp = '0;
    case (act)
      ACT_PM:  pp = m_ext;
      ACT_P2M: pp = m_ext << 1;
      ACT_NM:  pp = -m_ext;
      ACT_N2M: pp = -(m_ext << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one Booth group per clock, valid/ready on both sides.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all equal.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH:0]     b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2:0]         grp;
  logic [2:0]         act;
  logic [WIDTH+1:0]   pp;
  logic [2*WIDTH-1:0] pp_ext;
  logic [2*WIDTH-1:0] pp_shift;
  logic               last_grp;

  // b_reg holds the multiplier above a zero guard bit, so group cnt sits at bit 2*cnt
  assign grp      = b_reg[{cnt, 1'b0} +: 3];
  assign act      = booth_encode(grp);
  assign pp_ext   = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
  assign pp_shift = pp_ext << {cnt, 1'b0};

  booth_pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp_gen (
    .act (act),
    .m   (m_reg),
    .pp  (pp)
  );

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0] b_rem;

  // Arithmetic shift leaves only b[WIDTH-1:2cnt+1] plus sign copies
  assign b_rem    = $signed(b_reg[WIDTH:1]) >>> {cnt, 1'b1};
  assign last_grp = (cnt == CW'(ITER - 1)) || (b_rem == '0) || (b_rem == '1);
`else
  assign last_grp = (cnt == CW'(ITER - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_grp) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg <= multiplicand;
            b_reg <= {multiplier, 1'b0};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc + pp_shift;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule
